dmem_store_buffer: RTL

Memory-stage companion to the pipelined MIPS datapath. It sits between the datapath's data-memory port and a slow, handshaked memory bus. Stores are posted into a small FIFO and drained in the background. Loads are forwarded from the FIFO when it holds the address; otherwise they are fetched over the bus, and the pipeline is stalled until the data returns.

---
 rtl/dmem_store_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-store FIFO with load forwarding between MIPS memory stage and a handshaked bus
//
// Purpose: stores are posted into a DEPTH-entry FIFO and drained to the bus in
// the background; loads are forwarded from the youngest matching FIFO entry or
// fetched over the bus while the pipeline is stalled.
//
// Ports:
//   clk, reset_n          pipeline clock, asynchronous active-low reset
//   cpu_we, cpu_re        memory-stage store / load request (store wins if both)
//   cpu_addr, cpu_wdata   byte address (word access), store data
//   cpu_rdata             load data (combinational on hit, rdata_q in RDONE)
//   stall_mem             combinational pipeline freeze
//   bus_req, bus_we       bus request held until bus_ack, direction
//   bus_addr, bus_wdata   word-aligned address and write data
//   bus_ack, bus_rdata    one-cycle completion strobe and read data
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall_mem,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_RDONE} state_e;

  state_e           state_q, state_d;
  logic [29:0]      fifo_addr_q [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [29:0]      raddr_q, raddr_d;

  logic             full, empty, ld_req, hit, miss, push, pop;
  logic [31:0]      hit_data;
  logic [PTR_W-1:0] idx;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_addr[1:0];

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign ld_req = cpu_re & ~cpu_we;
  assign push   = cpu_we & ~full;
  assign pop    = (state_q == ST_WR) & bus_ack;
  assign miss   = ld_req & ~hit;

  // Walk from oldest to youngest so the last match found is the youngest.
  // The head entry stays visible while it is being drained.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx] == cpu_addr[31:2])) begin
        hit      = 1'b1;
        hit_data = fifo_data_q[idx];
      end
    end
  end

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d   = state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        // A waiting load outranks draining the store queue.
        if (miss) begin
          state_d = ST_RD;
          raddr_d = cpu_addr[31:2];
        end else if (!empty) begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {fifo_addr_q[head_q], 2'b00};
        bus_wdata = fifo_data_q[head_q];
        if (bus_ack) state_d = ST_IDLE;
      end
      ST_RD: begin
        bus_req  = 1'b1;
        bus_addr = {raddr_q, 2'b00};
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = ST_RDONE;
        end
      end
      ST_RDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // CPU-side outputs are forced low while reset is held, even with a request present.
  always_comb begin
    stall_mem = 1'b0;
    cpu_rdata = '0;
    if (reset_n) begin
      stall_mem = (cpu_we & full) | (miss & (state_q != ST_RDONE));
      if (ld_req) begin
        if (state_q == ST_RDONE) cpu_rdata = rdata_q;
        else if (hit)            cpu_rdata = hit_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      raddr_q <= raddr_d;
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= cpu_addr[31:2];
      fifo_data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule
